// File: rtl/pc_unit.sv
// pc_unit: IF-stage program counter with redirect buffering and a return-address stack.
// Optional misaligned-redirect filter enabled by defining PC_ALIGN_CHECK_EN.
module pc_unit #(
    parameter int PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int PC_INC = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                hazard_pc_i,
    input  logic                redirect_valid_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    input  logic                call_i,
    input  logic                ret_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                pc_valid_o,
    output logic                redirect_pending_o,
    output logic                ras_empty_o,
    output logic                ras_full_o
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                misalign_o
`endif
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              r_state, w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc, r_pend_pc, w_pc_nxt, w_inc;
    logic                r_pend, w_adv, w_stall, w_redir, w_pop, w_full, w_empty;
    logic [AW-1:0]       r_top, w_top_inc;
    logic [CW-1:0]       r_cnt;
    logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];

`ifdef PC_ALIGN_CHECK_EN
    logic r_misalign, w_aligned;
    assign w_aligned = (redirect_pc_i & PC_WIDTH'(PC_INC - 1)) == '0;
    assign w_redir = redirect_valid_i && w_aligned;
    assign misalign_o = r_misalign;

    always_ff @(posedge clk_i) begin
        if (!rst_i) r_misalign <= 1'b0;
        else r_misalign <= (w_adv || w_stall) && redirect_valid_i && !w_aligned;
    end
`else
    assign w_redir = redirect_valid_i;
`endif

    always_comb begin
        w_state_nxt = start_i ? RUN : IDLE;
        w_adv = r_state == RUN && start_i && !hazard_pc_i;
        w_stall = r_state == RUN && hazard_pc_i;
        w_inc = r_pc + PC_WIDTH'(PC_INC);
        w_top_inc = r_top + AW'(1);
        w_full = r_cnt == CW'(RAS_DEPTH);
        w_empty = r_cnt == '0;
        // A winning redirect or buffered target suppresses the pop entirely.
        w_pop = ret_i && !w_empty && !w_redir && !r_pend;
        w_pc_nxt = w_redir ? redirect_pc_i : r_pend ? r_pend_pc : w_pop ? r_ras[r_top] : w_inc;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_pc      <= RESET_VECTOR;
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
            r_top     <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_adv) begin
                r_pc   <= w_pc_nxt;
                r_pend <= 1'b0;
            end else if (w_stall && w_redir) begin
                r_pend    <= 1'b1;
                r_pend_pc <= redirect_pc_i;
            end
            if (w_adv && call_i && !w_pop) begin
                r_top <= w_top_inc;
                if (!w_full) r_cnt <= r_cnt + CW'(1);
            end else if (w_adv && w_pop && !call_i) begin
                r_top <= r_top - AW'(1);
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Call+ret overwrites the top in place; a plain push wraps over the oldest entry.
    always_ff @(posedge clk_i) begin
        if (rst_i && w_adv && call_i) r_ras[w_pop ? r_top : w_top_inc] <= w_inc;
    end

    assign pc_o = r_pc;
    assign pc_valid_o = r_state == RUN;
    assign redirect_pending_o = r_pend;
    assign ras_empty_o = w_empty;
    assign ras_full_o = w_full;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit (32-bit default instance plus an 8-bit wrap instance).
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        rst_i, start_i, hazard_pc_i, redirect_valid_i, call_i, ret_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_o;
    logic [7:0]  pc8_o;
    logic        pc_valid_o, redirect_pending_o, ras_empty_o, ras_full_o;
    logic        v8, p8, e8, f8;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_o, m8;
`endif
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_unit u_dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .hazard_pc_i(hazard_pc_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .call_i(call_i), .ret_i(ret_i), .pc_o(pc_o), .pc_valid_o(pc_valid_o),
        .redirect_pending_o(redirect_pending_o), .ras_empty_o(ras_empty_o),
        .ras_full_o(ras_full_o)
`ifdef PC_ALIGN_CHECK_EN
        , .misalign_o(misalign_o)
`endif
    );

    pc_unit #(.PC_WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .hazard_pc_i(hazard_pc_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i[7:0]),
        .call_i(call_i), .ret_i(ret_i), .pc_o(pc8_o), .pc_valid_o(v8),
        .redirect_pending_o(p8), .ras_empty_o(e8), .ras_full_o(f8)
`ifdef PC_ALIGN_CHECK_EN
        , .misalign_o(m8)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; hazard_pc_i = 1'b0; redirect_valid_i = 1'b0;
        redirect_pc_i = '0; call_i = 1'b0; ret_i = 1'b0;
        tick(); tick();
        check("rst_pc", pc_o, 32'h0);
        check("rst_valid", pc_valid_o, 1'b0);
        check("rst_pend", redirect_pending_o, 1'b0);
        check("rst_empty", ras_empty_o, 1'b1);
        check("rst_full", ras_full_o, 1'b0);
        rst_i = 1'b1; start_i = 1'b1;
        check("idle_pc", pc_o, 32'h0);
        tick();
        check("run_pc0", pc_o, 32'h0);
        check("run_valid", pc_valid_o, 1'b1);
        tick(); check("seq_4", pc_o, 32'h4);
        tick(); check("seq_8", pc_o, 32'h8);
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h100;
        tick(); check("redir_100", pc_o, 32'h100);
        redirect_valid_i = 1'b0;
        tick(); check("redir_104", pc_o, 32'h104);
        // stall with two redirects, last one wins
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h20;
        tick(); check("to_20", pc_o, 32'h20);
        redirect_valid_i = 1'b0; hazard_pc_i = 1'b1;
        tick(); check("stall1_pc", pc_o, 32'h20);
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h80;
        tick(); check("stall2_pc", pc_o, 32'h20);
        check("stall2_pend", redirect_pending_o, 1'b1);
        redirect_pc_i = 32'h90;
        tick(); check("stall3_pc", pc_o, 32'h20);
        check("stall3_pend", redirect_pending_o, 1'b1);
        hazard_pc_i = 1'b0; redirect_valid_i = 1'b0;
        tick(); check("release_pc", pc_o, 32'h90);
        check("release_pend", redirect_pending_o, 1'b0);
        tick(); check("release_94", pc_o, 32'h94);
        // call/return
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h10;
        tick(); check("to_10", pc_o, 32'h10);
        call_i = 1'b1; redirect_pc_i = 32'h200;
        tick(); check("jal_pc", pc_o, 32'h200);
        check("jal_nonempty", ras_empty_o, 1'b0);
        call_i = 1'b0; redirect_valid_i = 1'b0;
        tick(); tick(); check("at_208", pc_o, 32'h208);
        ret_i = 1'b1;
        tick(); check("ret_14", pc_o, 32'h14);
        check("ret_empty", ras_empty_o, 1'b1);
        // five nested calls into a 4-deep stack
        ret_i = 1'b0; call_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("nest_pc", pc_o, 32'h28);
        check("nest_full", ras_full_o, 1'b1);
        call_i = 1'b0; ret_i = 1'b1;
        tick(); check("pop1", pc_o, 32'h28);
        tick(); check("pop2", pc_o, 32'h24);
        tick(); check("pop3", pc_o, 32'h20);
        check("pop3_notfull", ras_full_o, 1'b0);
        tick(); check("pop4", pc_o, 32'h1c);
        check("pop4_empty", ras_empty_o, 1'b1);
        tick(); check("pop5_seq", pc_o, 32'h20);
        // call+ret together on a non-empty stack
        ret_i = 1'b0; call_i = 1'b1;
        tick(); check("cr_push", pc_o, 32'h24);
        ret_i = 1'b1;
        tick(); check("cr_both", pc_o, 32'h24);
        check("cr_count", ras_empty_o, 1'b0);
        call_i = 1'b0;
        tick(); check("cr_ret", pc_o, 32'h28);
        check("cr_empty", ras_empty_o, 1'b1);
        ret_i = 1'b0; start_i = 1'b0;
        tick(); check("idle_hold", pc_o, 32'h28);
        check("idle_valid", pc_valid_o, 1'b0);
        start_i = 1'b1;
        tick(); check("rerun_pc", pc_o, 32'h28);
        // reset mid-operation with pending redirect and stack contents
        call_i = 1'b1;
        tick(); check("pre_rst_pc", pc_o, 32'h2c);
        call_i = 1'b0; hazard_pc_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h300;
        tick(); check("pre_rst_pend", redirect_pending_o, 1'b1);
        rst_i = 1'b0; hazard_pc_i = 1'b0; redirect_valid_i = 1'b0;
        tick();
        check("mid_rst_pc", pc_o, 32'h0);
        check("mid_rst_pend", redirect_pending_o, 1'b0);
        check("mid_rst_empty", ras_empty_o, 1'b1);
        check("mid_rst_valid", pc_valid_o, 1'b0);
        rst_i = 1'b1;
        tick(); check("post_rst_pc", pc_o, 32'h0);
        // 8-bit wrap
        redirect_valid_i = 1'b1; redirect_pc_i = 32'hfc;
        tick(); check("w8_fc", {24'h0, pc8_o}, 32'hfc);
        redirect_valid_i = 1'b0;
        tick(); check("w8_wrap", {24'h0, pc8_o}, 32'h0);
        check("w32_nowrap", pc_o, 32'h100);
`ifdef PC_ALIGN_CHECK_EN
        check("mis_idle", misalign_o, 1'b0);
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h102;
        tick(); check("mis_pc", pc_o, 32'h104);
        check("mis_pulse", misalign_o, 1'b1);
        redirect_valid_i = 1'b0;
        tick(); check("mis_next", pc_o, 32'h108);
        check("mis_clear", misalign_o, 1'b0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter generator for the IF stage. Successor to the single 32-bit PC register.
- Adds configurable width, reset vector and increment, plus a redirect input with priority.
- A redirect that arrives during a hazard stall is held and applied when the stall releases.
- Includes an internal return-address stack (RAS) for call/return prediction.
- Feeds instruction memory and the IF/ID pipeline register.

Parameters:
- PC_WIDTH, 32, width of PC and all address ports.
- RESET_VECTOR, 0, PC value after reset.
- PC_INC, 4, sequential increment. Power of two, at least 1.
- RAS_DEPTH, 4, return-address-stack entries. Power of two, at least 2.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous active-low reset.
- start_i  input  1  run enable. PC advances only while high.
- hazard_pc_i  input  1  stall from the hazard unit. PC holds while high.
- redirect_valid_i  input  1  branch/jump taken this cycle.
- redirect_pc_i  input  PC_WIDTH  redirect target.
- call_i  input  1  push return address (pc_o+PC_INC).
- ret_i  input  1  pop RAS and redirect to the popped address.
- pc_o  output  PC_WIDTH  current PC.
- pc_valid_o  output  1  high while in RUN.
- redirect_pending_o  output  1  a buffered redirect is waiting.
- ras_empty_o  output  1  RAS holds no entries.
- ras_full_o  output  1  RAS holds RAS_DEPTH entries.
- misalign_o  output  1  misaligned-redirect pulse. Present only with the optional feature.

Behaviour:
- Reset (rst_i=0 at a rising edge, any state), values on the following cycle:
  - pc_o=RESET_VECTOR, pc_valid_o=0, redirect_pending_o=0, misalign_o=0.
  - RAS emptied: ras_empty_o=1, ras_full_o=0.
  - State goes to IDLE. A reset in mid-operation discards pending redirects and RAS contents.
- States:
  - IDLE: pc_o holds. start_i=1 -> RUN next cycle. pc_o is unchanged on the transition cycle and pc_valid_o rises.
  - RUN: start_i=0 -> IDLE next cycle. pc_o holds, the pending redirect is retained, call_i/ret_i are ignored that cycle.
- Advance cycle = RUN, start_i=1, hazard_pc_i=0. Next-PC priority on an advance cycle:
  1. redirect_valid_i -> redirect_pc_i. This also clears any pending redirect.
  2. Pending redirect -> buffered target. The pending flag clears.
  3. ret_i with RAS not empty -> RAS top, which is popped.
  4. Otherwise -> pc_o+PC_INC, modulo 2^PC_WIDTH (wrap-around, no flag).
- ret_i with the RAS empty: sequential increment, no error.
- call_i on an advance cycle pushes pc_o+PC_INC. It may coincide with a redirect (jump-and-link).
- If a redirect or pending target wins, ret_i is ignored and no pop occurs.
- call_i and ret_i together, RAS not empty: target = old top. The top entry is overwritten with pc_o+PC_INC and the count is unchanged.
- call_i and ret_i together, RAS empty: a push only.
- Push when full: the oldest entry is overwritten (circular). The count stays RAS_DEPTH and ras_full_o stays 1.
- Stall cycle (RUN, hazard_pc_i=1):
  - pc_o holds. call_i/ret_i are ignored.
  - redirect_valid_i captures redirect_pc_i into the pending buffer and sets redirect_pending_o on the next cycle.
  - Several redirects during one stall: the last one wins.
- Latency:
  - A redirect on an advance cycle is visible on pc_o the next cycle.
  - A buffered redirect is visible one cycle after the first advance cycle.
- All state changes occur on the rising edge of clk_i only. There are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A redirect target whose low log2(PC_INC) bits are non-zero is discarded: not applied and not buffered.
  - misalign_o pulses 1 for one cycle, on the cycle after the offending input.
  - That cycle behaves as if redirect_valid_i=0 (the lower priorities apply).
- Not defined: no check is made, targets are used verbatim, and the misalign_o port is absent.

Test Plan:
- Reset then start: rst_i low 2 cycles, start_i=1 -> pc_o=0,0,4,8,12 and pc_valid_o rises on the first hold cycle.
- Redirect: at pc_o=8, redirect_valid_i=1 with 0x100 -> next pc_o=0x100, then 0x104.
- Stall with redirect: hazard_pc_i=1 for 3 cycles at pc_o=0x20, redirect to 0x80 on stall cycle 2, then 0x90 on stall cycle 3:
  - pc_o holds at 0x20 and redirect_pending_o=1.
  - After release, pc_o=0x90, pending clears, then 0x94.
- RAS:
  - call_i at 0x10 with redirect to 0x200, then ret_i at 0x208 -> pc_o=0x14.
  - 5 nested calls with RAS_DEPTH=4 -> ras_full_o=1. Four rets return the 4 newest addresses, then ras_empty_o=1 and the fifth ret gives sequential +4.
- Wrap and mid-operation reset:
  - PC_WIDTH=8, pc_o=0xFC -> next 0x00.
  - rst_i low while redirect_pending_o=1 -> pc_o=RESET_VECTOR, pending=0, ras_empty_o=1, state IDLE.
- With PC_ALIGN_CHECK_EN: redirect to 0x102 -> pc_o advances +4, misalign_o=1 for exactly one cycle.
